tft_scan_ctr: RTL and testbench

TFT_SCAN_CTR -- requirements
Module: tft_scan_ctr

---
 rtl/tft_scan_ctr_if.sv | 29 ++
 rtl/tft_scan_ctr.sv | 178 +++++++++++++++++
 tb/tb_tft_scan_ctr.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/tft_scan_ctr_if.sv
// Port-B connection between the TFT scan controller and the dual-port frame buffer.
interface tft_scan_ctr_if;
    localparam int unsigned ADDR_W = 19;
    localparam int unsigned DATA_W = 8;

    logic              enb_o;
    logic              web_o;
    logic [ADDR_W-1:0] addrb_o;
    logic [DATA_W-1:0] d2memb_o;
    logic [DATA_W-1:0] mem2db_i;

    // Scan controller side: drives the read request, receives gray data
    modport master (
        output enb_o,
        output web_o,
        output addrb_o,
        output d2memb_o,
        input  mem2db_i
    );

    // Frame buffer side
    modport slave (
        input  enb_o,
        input  web_o,
        input  addrb_o,
        input  d2memb_o,
        output mem2db_i
    );
endinterface

// File: rtl/tft_scan_ctr.sv
// TFT raster scan controller: generates timing, fetches a gray image window
// from the frame buffer port B and emits aligned RGB/DE/HSYNC/VSYNC.
module tft_scan_ctr #(
    parameter int unsigned H_ACTIVE = 1024,
    parameter int unsigned H_FP     = 160,
    parameter int unsigned H_SYNC   = 20,
    parameter int unsigned H_BP     = 140,
    parameter int unsigned V_ACTIVE = 600,
    parameter int unsigned V_FP     = 12,
    parameter int unsigned V_SYNC   = 3,
    parameter int unsigned V_BP     = 20,
    parameter int unsigned IMG_W    = 540,
    parameter int unsigned IMG_H    = 540,
    parameter int unsigned IMG_X0   = 242,
    parameter int unsigned IMG_Y0   = 30
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  bram_en_i,
    tft_scan_ctr_if.master        bram,
    output logic [23:0]           rgb_o,
    output logic                  de_o,
    output logic                  hsync_o,
    output logic                  vsync_o,
    output logic                  frame_start_o
);
    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HW      = $clog2(H_TOTAL);
    localparam int unsigned VW      = $clog2(V_TOTAL);
    localparam int unsigned AW      = 19;

    typedef enum logic {ST_IDLE, ST_RUN} state_t;

    state_t         r_state, w_state_nxt;
    logic [HW-1:0]  r_h_cnt, w_h_nxt;
    logic [VW-1:0]  r_v_cnt, w_v_nxt;
    logic [AW-1:0]  r_addr_cnt;

    logic           r_enb;
    logic [AW-1:0]  r_addrb;
    logic           r_s1_de, r_s1_hs, r_s1_vs, r_s1_fs;
    logic           r_s2_de, r_s2_hs, r_s2_vs, r_s2_fs, r_s2_win;
    logic [23:0]    r_rgb;
    logic           r_de, r_hs, r_vs, r_fs;

    logic           w_run, w_h_last, w_v_last;
    logic           w_de0, w_hs0, w_vs0, w_win0, w_fs0;

    assign w_run    = (r_state == ST_RUN);
    assign w_h_last = (r_h_cnt == HW'(H_TOTAL - 1));
    assign w_v_last = (r_v_cnt == VW'(V_TOTAL - 1));

    // State and raster counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_h_cnt <= w_h_nxt;
            r_v_cnt <= w_v_nxt;
        end
    end

    // Next state: a started frame always runs to its last pixel, where bram_en_i decides
    always_comb begin
        w_state_nxt = r_state;
        w_h_nxt     = r_h_cnt;
        w_v_nxt     = r_v_cnt;
        case (r_state)
            ST_IDLE: begin
                w_h_nxt = '0;
                w_v_nxt = '0;
                if (bram_en_i) w_state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (w_h_last) begin
                    w_h_nxt = '0;
                    if (w_v_last) begin
                        w_v_nxt = '0;
                        if (!bram_en_i) w_state_nxt = ST_IDLE;
                    end else begin
                        w_v_nxt = r_v_cnt + VW'(1);
                    end
                end else begin
                    w_h_nxt = r_h_cnt + HW'(1);
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Stage-0 timing decode from the counters; blanking values while idle
    assign w_de0  = w_run && (r_h_cnt < HW'(H_ACTIVE)) && (r_v_cnt < VW'(V_ACTIVE));
    assign w_hs0  = !(w_run && (r_h_cnt >= HW'(H_ACTIVE + H_FP))
                            && (r_h_cnt <  HW'(H_ACTIVE + H_FP + H_SYNC)));
    assign w_vs0  = !(w_run && (r_v_cnt >= VW'(V_ACTIVE + V_FP))
                            && (r_v_cnt <  VW'(V_ACTIVE + V_FP + V_SYNC)));
    assign w_win0 = w_run && (r_h_cnt >= HW'(IMG_X0)) && (r_h_cnt < HW'(IMG_X0 + IMG_W))
                          && (r_v_cnt >= VW'(IMG_Y0)) && (r_v_cnt < VW'(IMG_Y0 + IMG_H));
    assign w_fs0  = w_run && (r_h_cnt == '0) && (r_v_cnt == '0);

    // Linear image address: counts window pixels, restarts every frame
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr_cnt <= '0;
        end else if (!w_run || (w_h_last && w_v_last)) begin
            r_addr_cnt <= '0;
        end else if (w_win0) begin
            r_addr_cnt <= r_addr_cnt + AW'(1);
        end
    end

    // Stage 1: frame buffer read request plus delayed timing flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_enb   <= 1'b0;
            r_addrb <= '0;
            r_s1_de <= 1'b0;
            r_s1_hs <= 1'b1;
            r_s1_vs <= 1'b1;
            r_s1_fs <= 1'b0;
        end else begin
            r_enb   <= w_win0;
            if (w_win0) r_addrb <= r_addr_cnt;
            r_s1_de <= w_de0;
            r_s1_hs <= w_hs0;
            r_s1_vs <= w_vs0;
            r_s1_fs <= w_fs0;
        end
    end

    // Stage 2: wait out the one-cycle frame buffer read latency
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s2_de  <= 1'b0;
            r_s2_hs  <= 1'b1;
            r_s2_vs  <= 1'b1;
            r_s2_fs  <= 1'b0;
            r_s2_win <= 1'b0;
        end else begin
            r_s2_de  <= r_s1_de;
            r_s2_hs  <= r_s1_hs;
            r_s2_vs  <= r_s1_vs;
            r_s2_fs  <= r_s1_fs;
            r_s2_win <= r_enb;
        end
    end

    // Stage 3: aligned video outputs, gray replicated onto all three channels
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rgb <= '0;
            r_de  <= 1'b0;
            r_hs  <= 1'b1;
            r_vs  <= 1'b1;
            r_fs  <= 1'b0;
        end else begin
            r_rgb <= r_s2_win ? {bram.mem2db_i, bram.mem2db_i, bram.mem2db_i} : 24'h0;
            r_de  <= r_s2_de;
            r_hs  <= r_s2_hs;
            r_vs  <= r_s2_vs;
            r_fs  <= r_s2_fs;
        end
    end

    assign bram.enb_o    = r_enb;
    assign bram.addrb_o  = r_addrb;
    assign bram.web_o    = 1'b0;
    assign bram.d2memb_o = 8'h00;
    assign rgb_o         = r_rgb;
    assign de_o          = r_de;
    assign hsync_o       = r_hs;
    assign vsync_o       = r_vs;
    assign frame_start_o = r_fs;
endmodule

// File: tb/tb_tft_scan_ctr.sv
// Randomized bench for tft_scan_ctr against a per-pixel raster reference model,
// using a reduced screen geometry so several frames fit in a short run.
module tb_tft_scan_ctr;
    localparam int HA = 16, HF = 4, HS = 3, HB = 3;
    localparam int VA = 10, VF = 2, VS = 2, VB = 2;
    localparam int IW = 6,  IH = 5, IX = 4, IY = 3;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;

    logic        clk = 1'b0;
    logic        rst;
    logic        bram_en_i;
    logic [23:0] rgb_o;
    logic        de_o, hsync_o, vsync_o, frame_start_o;

    tft_scan_ctr_if u_bram ();

    tft_scan_ctr #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .IMG_W(IW), .IMG_H(IH), .IMG_X0(IX), .IMG_Y0(IY)
    ) u_dut (
        .clk           (clk),
        .rst           (rst),
        .bram_en_i     (bram_en_i),
        .bram          (u_bram),
        .rgb_o         (rgb_o),
        .de_o          (de_o),
        .hsync_o       (hsync_o),
        .vsync_o       (vsync_o),
        .frame_start_o (frame_start_o)
    );

    always #5 clk = ~clk;

    // Frame buffer model: one-cycle read latency, content = low address byte
    logic [7:0] mem_q = 8'h00;
    always @(posedge clk) if (u_bram.enb_o) mem_q <= u_bram.addrb_o[7:0];
    assign u_bram.mem2db_i = mem_q;

    typedef struct {
        bit win;
        int addr;
        bit de;
        bit hs;
        bit vs;
        bit fs;
    } desc_t;

    bit    m_run;
    int    m_h, m_v;
    desc_t hist [4];
    int    exp_addr;
    int    n_checks = 0;
    int    n_errors = 0;

    bit acc_on = 1'b0;
    int acc_de, acc_hs, acc_vs, acc_fs, acc_enb, acc_rgb_blank, acc_addr_max;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic desc_t blank();
        desc_t d;
        d = '{default: 0};
        d.hs = 1'b1;
        d.vs = 1'b1;
        return d;
    endfunction

    // What the screen should show for the model's current raster position
    function automatic desc_t describe();
        desc_t d;
        d = blank();
        if (m_run) begin
            d.de   = (m_h < HA) && (m_v < VA);
            d.hs   = !((m_h >= HA + HF) && (m_h < HA + HF + HS));
            d.vs   = !((m_v >= VA + VF) && (m_v < VA + VF + VS));
            d.win  = (m_h >= IX) && (m_h < IX + IW) && (m_v >= IY) && (m_v < IY + IH);
            d.addr = d.win ? (m_v - IY) * IW + (m_h - IX) : 0;
            d.fs   = (m_h == 0) && (m_v == 0);
        end
        return d;
    endfunction

    task automatic model_reset();
        m_run = 1'b0;
        m_h = 0;
        m_v = 0;
        for (int i = 0; i < 4; i++) hist[i] = blank();
        exp_addr = 0;
    endtask

    task automatic model_step(input bit en);
        if (!m_run) begin
            if (en) begin
                m_run = 1'b1;
                m_h = 0;
                m_v = 0;
            end
        end else if (m_h == HT - 1 && m_v == VT - 1) begin
            m_h = 0;
            m_v = 0;
            m_run = en;
        end else if (m_h == HT - 1) begin
            m_h = 0;
            m_v = m_v + 1;
        end else begin
            m_h = m_h + 1;
        end
    endtask

    task automatic check_reset_values(input string pfx);
        check({pfx, "enb_o"},    32'(u_bram.enb_o),    32'd0);
        check({pfx, "web_o"},    32'(u_bram.web_o),    32'd0);
        check({pfx, "addrb_o"},  32'(u_bram.addrb_o),  32'd0);
        check({pfx, "d2memb_o"}, 32'(u_bram.d2memb_o), 32'd0);
        check({pfx, "rgb_o"},    32'(rgb_o),           32'd0);
        check({pfx, "de_o"},     32'(de_o),            32'd0);
        check({pfx, "hsync_o"},  32'(hsync_o),         32'd1);
        check({pfx, "vsync_o"},  32'(vsync_o),         32'd1);
        check({pfx, "fs_o"},     32'(frame_start_o),   32'd0);
    endtask

    // One clock: compare outputs mid-cycle, then drive inputs for the next edge
    task automatic run_cycle(input bit en, input bit rs);
        logic [7:0]  g;
        logic [23:0] exp_rgb;
        @(negedge clk);
        for (int i = 3; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = describe();
        if (hist[1].win) exp_addr = hist[1].addr;
        g = 8'(hist[3].addr);
        exp_rgb = hist[3].win ? {g, g, g} : 24'h0;
        check("enb_o",    32'(u_bram.enb_o),    32'(hist[1].win));
        check("addrb_o",  32'(u_bram.addrb_o),  32'(exp_addr));
        check("web_o",    32'(u_bram.web_o),    32'd0);
        check("d2memb_o", 32'(u_bram.d2memb_o), 32'd0);
        check("rgb_o",    32'(rgb_o),           32'(exp_rgb));
        check("de_o",     32'(de_o),            32'(hist[3].de));
        check("hsync_o",  32'(hsync_o),         32'(hist[3].hs));
        check("vsync_o",  32'(vsync_o),         32'(hist[3].vs));
        check("fs_o",     32'(frame_start_o),   32'(hist[3].fs));
        if (acc_on) begin
            acc_de  += int'(de_o);
            acc_hs  += int'(!hsync_o);
            acc_vs  += int'(!vsync_o);
            acc_fs  += int'(frame_start_o);
            acc_enb += int'(u_bram.enb_o);
            if (!de_o && rgb_o != 24'h0) acc_rgb_blank++;
            if (u_bram.enb_o && int'(u_bram.addrb_o) > acc_addr_max) acc_addr_max = int'(u_bram.addrb_o);
        end
        rst = rs;
        bram_en_i = en;
        if (rs) model_reset();
        else model_step(en);
    endtask

    task automatic acc_clear();
        acc_de = 0; acc_hs = 0; acc_vs = 0; acc_fs = 0;
        acc_enb = 0; acc_rgb_blank = 0; acc_addr_max = -1;
    endtask

    // Run with en=1 until the model reaches (h,v); an expired bound is a failure
    task automatic run_to(input int h, input int v, input string tag);
        int guard;
        guard = 0;
        while (!(m_run && m_h == h && m_v == v) && guard < 4 * HT * VT) begin
            run_cycle(1'b1, 1'b0);
            guard++;
        end
        check({tag, "_reached"}, 32'(m_run && m_h == h && m_v == v), 32'd1);
    endtask

    initial begin
        int guard;
        rst = 1'b0;
        bram_en_i = 1'b0;
        acc_clear();
        model_reset();
        #2 rst = 1'b1;
        #1 check_reset_values("rst0_");

        repeat (3) run_cycle(1'b0, 1'b1);
        repeat (4) run_cycle(1'b0, 1'b0);

        // Continuous scanning; measure one full frame of steady output
        repeat (12) run_cycle(1'b1, 1'b0);
        acc_clear();
        acc_on = 1'b1;
        repeat (HT * VT) run_cycle(1'b1, 1'b0);
        acc_on = 1'b0;
        check("frame_de_cycles",   32'(acc_de),        32'(HA * VA));
        check("frame_hsync_low",   32'(acc_hs),        32'(HS * VT));
        check("frame_vsync_low",   32'(acc_vs),        32'(VS * HT));
        check("frame_start_count", 32'(acc_fs),        32'd1);
        check("frame_enb_count",   32'(acc_enb),       32'(IW * IH));
        check("frame_addr_max",    32'(acc_addr_max),  32'(IW * IH - 1));
        check("rgb_in_blanking",   32'(acc_rgb_blank), 32'd0);

        // Random enable: mid-frame drops must not abort, frame end decides
        repeat (3000) run_cycle(1'($urandom_range(0, 1)), 1'b0);

        // Drop enable at line 5: frame completes, then stays idle
        run_to(0, 5, "drop_v5");
        guard = 0;
        while (m_run && guard < 2 * HT * VT) begin
            run_cycle(1'b0, 1'b0);
            guard++;
        end
        check("drop_frame_ended", 32'(m_run), 32'd0);
        acc_clear();
        acc_on = 1'b1;
        repeat (60) run_cycle(1'b0, 1'b0);
        acc_on = 1'b0;
        check("idle_no_enb", 32'(acc_enb), 32'd0);
        check("idle_no_de",  32'(acc_de),  32'd0);

        // Asynchronous reset in the middle of a frame
        run_to(10, 7, "mid_rst");
        #2 rst = 1'b1;
        #1 check_reset_values("midrst_");
        model_reset();
        repeat (3) run_cycle(1'b1, 1'b1);
        repeat (HT * VT + 20) run_cycle(1'b1, 1'b0);

        // Enable sampled at the last pixel decides: low -> idle, high -> wrap
        run_to(HT - 1, VT - 1, "end_low");
        run_cycle(1'b0, 1'b0);
        repeat (10) run_cycle(1'b0, 1'b0);
        run_cycle(1'b1, 1'b0);
        run_to(HT - 2, VT - 1, "end_high");
        run_cycle(1'b0, 1'b0);
        run_cycle(1'b1, 1'b0);
        repeat (HT * 3) run_cycle(1'b0, 1'b0);
        guard = 0;
        while (m_run && guard < 2 * HT * VT) begin
            run_cycle(1'b0, 1'b0);
            guard++;
        end
        repeat (8) run_cycle(1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", n_checks, n_errors);
        $fatal(1, "watchdog expired");
    end
endmodule
